// File: rtl/vram_rect_filler.sv
// Rectangle-fill drawing engine: one VRAM pixel write per iCLK in raster order (x inner, y outer).
// Optional build macro CLEAR_ON_RESET_EN adds a power-up sweep of all 65536 addresses with CLEAR_COLOR.
module vram_rect_filler #(
  parameter logic [8:0] CLEAR_COLOR = 9'h000,
  parameter int         SIZE_W      = 9
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iCmd_Valid,
  output logic              oCmd_Ready,
  input  logic [7:0]        iCmd_X0,
  input  logic [7:0]        iCmd_Y0,
  input  logic [SIZE_W-1:0] iCmd_W,
  input  logic [SIZE_W-1:0] iCmd_H,
  input  logic [8:0]        iCmd_Color,
  output logic              oBusy,
  output logic              oDone,
  output logic [7:0]        write_x,
  output logic [7:0]        write_y,
  output logic [2:0]        write_r,
  output logic [2:0]        write_g,
  output logic [2:0]        write_b
);

  typedef enum logic [1:0] {CLEAR, IDLE, FILL, DONE} stateT;

  stateT             state, nextState;
  logic [7:0]        x0Reg;
  logic [SIZE_W-1:0] wReg, hReg, colCnt, rowCnt;
  logic              accept, cmdEmpty, colLast, lastPixel;

`ifdef CLEAR_ON_RESET_EN
  localparam stateT ResetState = CLEAR;
  logic clearArmed;
  logic clearLast;
  // The first CLEAR cycle loads CLEAR_COLOR at (0,0); the sweep proper starts after it.
  assign clearLast = clearArmed && (write_x == 8'hFF) && (write_y == 8'hFF);
`else
  localparam stateT ResetState = IDLE;
  logic unusedClearColor;
  assign unusedClearColor = ^CLEAR_COLOR;
`endif

  assign cmdEmpty  = (iCmd_W == '0) || (iCmd_H == '0);
  assign colLast   = (colCnt == wReg - SIZE_W'(1));
  assign lastPixel = colLast && (rowCnt == hReg - SIZE_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= ResetState;
    else         state <= nextState;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    nextState  = state;
    oCmd_Ready = 1'b0;
    oBusy      = 1'b1;
    oDone      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        oCmd_Ready = 1'b1;
        oBusy      = 1'b0;
        if (iCmd_Valid) begin
          accept    = 1'b1;
          nextState = cmdEmpty ? DONE : FILL;
        end
      end
      FILL: if (lastPixel) nextState = DONE;
      DONE: begin
        oDone     = 1'b1;
        nextState = IDLE;
      end
      default: begin
`ifdef CLEAR_ON_RESET_EN
        if (clearLast) nextState = IDLE;
`else
        nextState = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x0Reg   <= '0;
      wReg    <= '0;
      hReg    <= '0;
      colCnt  <= '0;
      rowCnt  <= '0;
      write_x <= '0;
      write_y <= '0;
      write_r <= '0;
      write_g <= '0;
      write_b <= '0;
`ifdef CLEAR_ON_RESET_EN
      clearArmed <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          x0Reg  <= iCmd_X0;
          wReg   <= iCmd_W;
          hReg   <= iCmd_H;
          colCnt <= '0;
          rowCnt <= '0;
          // Empty rectangles leave the write port untouched.
          if (!cmdEmpty) begin
            write_x                     <= iCmd_X0;
            write_y                     <= iCmd_Y0;
            {write_r, write_g, write_b} <= iCmd_Color;
          end
        end
        FILL: if (!lastPixel) begin
          if (colLast) begin
            colCnt  <= '0;
            rowCnt  <= rowCnt + SIZE_W'(1);
            write_x <= x0Reg;
            write_y <= write_y + 8'd1;
          end else begin
            colCnt  <= colCnt + SIZE_W'(1);
            write_x <= write_x + 8'd1;
          end
        end
`ifdef CLEAR_ON_RESET_EN
        CLEAR: begin
          if (!clearArmed) begin
            clearArmed                  <= 1'b1;
            {write_r, write_g, write_b} <= CLEAR_COLOR;
          end else if (!clearLast) begin
            write_x <= write_x + 8'd1;
            if (write_x == 8'hFF) write_y <= write_y + 8'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vram_rect_filler.md
Name: vram_rect_filler

Overview:
- Upstream drawing engine that produces the VRAM write port (write_x/write_y/write_r/g/b) of the 800x600 VGA controller's 256x256x9 frame buffer.
- Accepts rectangle-fill commands over a valid/ready handshake and emits one pixel write per iCLK in raster order.
- The VRAM write enable is permanently asserted, so every output cycle is a write. When idle, the block holds the last pixel and keeps rewriting the same value, which is harmless.

Parameters:
- CLEAR_COLOR, 9'h000: {r,g,b} value used by the optional power-up clear sweep.
- SIZE_W, 9: width of the W/H fields; range 0..256.

Ports:
- iCLK  in  1  pixel clock (40 MHz), shared with the VGA controller.
- iRST_N  in  1  reset.
- iCmd_Valid  in  1  command valid.
- oCmd_Ready  out  1  high only in IDLE.
- iCmd_X0  in  8  left column.
- iCmd_Y0  in  8  top row.
- iCmd_W  in  SIZE_W  width in pixels.
- iCmd_H  in  SIZE_W  height in pixels.
- iCmd_Color  in  9  {r[2:0],g[2:0],b[2:0]}.
- oBusy  out  1  high in any state other than IDLE.
- oDone  out  1  one-cycle pulse on command completion.
- write_x  out  8  VRAM column.
- write_y  out  8  VRAM row.
- write_r  out  3  red.
- write_g  out  3  green.
- write_b  out  3  blue.

Behaviour:
- Reset: iRST_N is asynchronous, active-low; clock is iCLK. On reset, all outputs are 0, oCmd_Ready=1 (oCmd_Ready=0 if CLEAR_ON_RESET_EN), state=IDLE (CLEAR if the macro is enabled). Reset mid-command aborts immediately and does not pulse oDone.
- States: CLEAR, IDLE, FILL, DONE.
- IDLE:
  - oCmd_Ready=1.
  - Accept when iCmd_Valid&&oCmd_Ready at edge T; latch X0, Y0, W, H and Color.
  - If W==0 or H==0, go to DONE, with no change to the write_* outputs.
  - Otherwise, at the same edge load write_x=X0, write_y=Y0, colour=Color, and go to FILL.
- FILL:
  - Each cycle advances one pixel; x is the inner loop, y the outer.
  - Internal column counter i runs 0..W-1; row counter j runs 0..H-1.
  - write_x = X0+i and write_y = Y0+j, both truncated to 8 bits, so coordinates wrap modulo 256 with no clipping.
  - After pixel (W-1,H-1) has been presented for one cycle, go to DONE; write_* hold that last pixel.
  - iCmd_Valid is ignored while in FILL.
- DONE: oDone=1 for exactly one cycle, then IDLE.
- Timing:
  - The first pixel is visible in cycle T+1.
  - The last pixel is visible in cycle T+W*H.
  - oDone is high in cycle T+W*H+1.
  - oCmd_Ready returns in cycle T+W*H+2.
  - For an empty command, oDone is high in T+1 and ready returns in T+2.
- Counters are SIZE_W bits wide. W=256 must produce 256 distinct columns (i reaches 255 without overflow).
- Outputs are registered, with no combinational path from the command inputs to write_*.
- Commands must not be dropped. A held iCmd_Valid is accepted only in IDLE.

Optional Feature:
- CLEAR_ON_RESET_EN defined:
  - After reset, state CLEAR sweeps all 65536 addresses (x inner, y outer, starting at (0,0)), one per cycle, with colour=CLEAR_COLOR.
  - oBusy=1 and oCmd_Ready=0 throughout the sweep.
  - After address (255,255), go directly to IDLE with no oDone pulse. oCmd_Ready=1 in the cycle after (255,255) is presented.
- Not defined: the CLEAR state is absent and reset enters IDLE directly.

Test Plan:
1. Reset (macro off) -> all write_* = 0, oCmd_Ready=1, oBusy=0, oDone=0.
2. Command X0=10, Y0=20, W=3, H=2, Color=9'h1C0 -> cycles T+1..T+6 present (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) with r=7, g=0, b=0; oDone at T+7; ready at T+8.
3. Wrap: X0=254, Y0=255, W=4, H=2, Color=9'h007 -> x sequence 254,255,0,1 on y=255, then the same x sequence on y=0; b=7.
4. W=0, H=5 with iCmd_Valid held high -> no write_* change; oDone at T+1; second command accepted at T+2.
5. iRST_N dropped mid-fill of W=256, H=256 -> outputs go to 0 asynchronously, no oDone, IDLE after release; full-frame command then takes 65536 fill cycles with x reaching 255.
6. CLEAR_ON_RESET_EN, CLEAR_COLOR=9'h049 -> 65536 writes (0,0)..(255,255) with r=1, g=1, b=1; oCmd_Ready rises in the cycle after (255,255); no oDone.
